// File: rtl/filter_xform_sched_if.sv
// Weight-buffer read port and transformed-buffer write port of filter_xform_sched.
// master: the scheduler. slave: the buffers.
interface filter_xform_sched_if #(
    parameter int W      = 8,
    parameter int ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [9*W-1:0]    rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [16*W-1:0]   wr_data;

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_data, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_data, wr_ready
    );
endinterface

// File: rtl/filter_xform_sched.sv
// Sequences a batch of 3x3 filters through the 2-cycle Winograd filter transform.
// Reads filters, tracks in-flight transforms with a valid shift register, and
// buffers results in a skid FIFO that drains over a valid/ready write port.
// Optional: define FXF_STALL_CNT_EN to add the stall_cycles output.
module filter_xform_sched #(
    parameter int W          = 8,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_W:0]      num_filters,
    input  logic [ADDR_W-1:0]    base_rd_addr,
    input  logic [ADDR_W-1:0]    base_wr_addr,
    output logic                 busy,
    output logic                 done,
    output logic [9*W-1:0]       xf_filter,
    input  logic [16*W-1:0]      xf_out,
`ifdef FXF_STALL_CNT_EN
    output logic [15:0]          stall_cycles,
`endif
    filter_xform_sched_if.master mem
);
    localparam int STAGES = RD_LAT + 2;
    localparam int IF_W   = $clog2(STAGES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SUM_W  = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  FIFO_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start_q;
    logic              accept;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   issued;
    logic              last_issue;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              rd_en;
    logic [STAGES-1:0] vld_sr;
    logic [IF_W-1:0]   inflight;
    logic [SUM_W-1:0]  credit_sum;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic              wr_valid;
    logic              drain_clear;
    logic [16*W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  fifo_count;

    // start is registered so the batch parameters are held before the FSM leaves IDLE;
    // a start in the gap cycle is rejected like one arriving while busy.
    assign accept     = start && (state == S_IDLE) && !start_q;
    assign last_issue = ((issued + CNT_ONE) == n_q);
    assign inflight   = IF_W'($countones(vld_sr));
    assign credit_sum = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign credit_ok  = (credit_sum < SUM_W'(FIFO_DEPTH));
    assign push       = vld_sr[STAGES-1];
    assign wr_valid   = (fifo_count != '0);
    assign pop        = wr_valid && mem.wr_ready;
    // Leave DRAIN on the cycle the final entry is popped, so done follows the last write directly.
    assign drain_clear = (inflight == '0) &&
                         ((fifo_count == '0) || ((fifo_count == FIFO_ONE) && pop));

    assign xf_filter    = mem.rd_data;
    assign mem.rd_en    = rd_en;
    assign mem.rd_addr  = rd_addr_q;
    assign mem.wr_valid = wr_valid;
    assign mem.wr_addr  = wr_addr_q;
    assign mem.wr_data  = fifo_mem[rptr];

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_q) state_nxt = (n_q == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (rd_en && last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_clear) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; reads are issued only while FIFO space is reserved for them
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        case (state)
            S_ISSUE: begin
                busy  = 1'b1;
                rd_en = credit_ok;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Batch parameter capture and issue/address counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q   <= 1'b0;
            n_q       <= '0;
            issued    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            start_q <= accept;
            if (accept) begin
                n_q       <= num_filters;
                issued    <= '0;
                rd_addr_q <= base_rd_addr;
                wr_addr_q <= base_wr_addr;
            end else begin
                if (rd_en) begin
                    issued    <= issued + CNT_ONE;
                    rd_addr_q <= rd_addr_q + ADDR_ONE;
                end
                if (pop) wr_addr_q <= wr_addr_q + ADDR_ONE;
            end
        end
    end

    // In-flight tracker: tail bit marks the cycle xf_out holds that filter's result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vld_sr <= '0;
        else       vld_sr <= {vld_sr[STAGES-2:0], rd_en};
    end

    // Skid FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= xf_out;
    end

    // Skid FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FIFO_ONE;
                2'b01:   fifo_count <= fifo_count - FIFO_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef FXF_STALL_CNT_EN
    // Saturating count of cycles lost to issue back-pressure or write stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if ((((state == S_ISSUE) && !rd_en) || (wr_valid && !mem.wr_ready)) &&
                     (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filter_xform_sched.sv
// Directed testbench for filter_xform_sched (W=8, ADDR_W=10, RD_LAT=1, FIFO_DEPTH=4).
// Models the weight buffer and the 2-cycle transform; checks order, addresses, timing.
module tb_filter_xform_sched;
    logic         clk;
    logic         rstn;
    logic         start;
    logic [10:0]  num_filters;
    logic [9:0]   base_rd_addr;
    logic [9:0]   base_wr_addr;
    logic         busy;
    logic         done;
    logic [71:0]  xf_filter;
    logic [127:0] xf_out;
`ifdef FXF_STALL_CNT_EN
    logic [15:0]  stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    filter_xform_sched_if #(.W(8), .ADDR_W(10)) mif ();

    filter_xform_sched #(
        .W(8), .ADDR_W(10), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .num_filters  (num_filters),
        .base_rd_addr (base_rd_addr),
        .base_wr_addr (base_wr_addr),
        .busy         (busy),
        .done         (done),
        .xf_filter    (xf_filter),
        .xf_out       (xf_out),
`ifdef FXF_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .mem          (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- models ----------------
    function automatic logic [71:0] filt_of(input int a);
        logic [71:0] f;
        for (int j = 0; j < 9; j++) f[j*8 +: 8] = 8'((a * 5 + j * 3 + 1) % 13);
        return f;
    endfunction

    // G*g*G^T with G scaled by 2 to keep integer coefficients; 8-bit wrap per element
    function automatic logic [127:0] gold_xform(input logic [71:0] g);
        int gm [4][3];
        int t  [4][3];
        int u;
        logic [127:0] r;
        gm = '{'{2, 0, 0}, '{1, 1, 1}, '{1, -1, 1}, '{0, 0, 2}};
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) begin
                t[i][c] = 0;
                for (int k = 0; k < 3; k++) t[i][c] += gm[i][k] * int'(g[(k*3+c)*8 +: 8]);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                u = 0;
                for (int k = 0; k < 3; k++) u += t[i][k] * gm[j][k];
                r[(i*4+j)*8 +: 8] = u[7:0];
            end
        return r;
    endfunction

    logic [71:0]  wmem [0:1023];
    logic [127:0] xf_s1;

    always @(posedge clk) if (mif.rd_en) mif.rd_data <= wmem[mif.rd_addr];

    always @(posedge clk) begin
        xf_s1  <= gold_xform(xf_filter);
        xf_out <= xf_s1;
    end

    // ---------------- monitor ----------------
    int cyc = 0, start_cyc = 0, first_rd = 0, last_rd = 0, first_wv = 0, last_wr = 0;
    int done_cyc = 0, done_cnt = 0, rd_cnt = 0, wv_cnt = 0;
    int mon_n = 0, mon_iss = 0, stall_mon = 0;
    int rd_q [$];
    int wa_q [$];
    logic [127:0] wd_q [$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (start) start_cyc = cyc;
            if ((busy && (mon_iss < mon_n) && !mif.rd_en) || (mif.wr_valid && !mif.wr_ready))
                stall_mon++;
            if (mif.rd_en) begin
                if (rd_cnt == 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
                mon_iss++;
                rd_q.push_back(int'(mif.rd_addr));
            end
            if (mif.wr_valid) begin
                if (wv_cnt == 0) first_wv = cyc;
                wv_cnt++;
            end
            if (mif.wr_valid && mif.wr_ready) begin
                last_wr = cyc;
                wd_q.push_back(mif.wr_data);
                wa_q.push_back(int'(mif.wr_addr));
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        rd_cnt = 0; wv_cnt = 0; done_cnt = 0; mon_iss = 0; stall_mon = 0;
        first_rd = 0; last_rd = 0; first_wv = 0; last_wr = 0; done_cyc = 0;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    task automatic kick(input int n, input int ra, input int wa);
        clear_mon();
        mon_n        = n;
        num_filters  = 11'(n);
        base_rd_addr = 10'(ra);
        base_wr_addr = 10'(wa);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > d0) break;
            step();
        end
        check_eq(tag, done_cnt - d0, 1);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"},     busy,         0);
        check_eq({tag, "_done"},     done,         0);
        check_eq({tag, "_rd_en"},    mif.rd_en,    0);
        check_eq({tag, "_rd_addr"},  mif.rd_addr,  0);
        check_eq({tag, "_wr_valid"}, mif.wr_valid, 0);
        check_eq({tag, "_wr_addr"},  mif.wr_addr,  0);
    endtask

    task automatic check_batch(input string tag, input int n, input int ra, input int wa);
        check_eq({tag, "_nrd"}, rd_q.size(), n);
        check_eq({tag, "_nwr"}, wd_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < rd_q.size()) check_eq({tag, "_rdaddr"}, rd_q[k], (ra + k) % 1024);
            if (k < wd_q.size()) begin
                check_eq({tag, "_wraddr"}, wa_q[k], (wa + k) % 1024);
                check_eq({tag, "_wrdata"}, wd_q[k], gold_xform(filt_of((ra + k) % 1024)));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] held_data;
        logic [9:0]   held_addr;
        int           d0;

        for (int a = 0; a < 1024; a++) wmem[a] = filt_of(a);
        rstn = 1'b0; start = 1'b0; num_filters = '0;
        base_rd_addr = '0; base_wr_addr = '0; mif.wr_ready = 1'b1;
        clear_mon();
        repeat (3) step();
        check_reset("rst");
        rstn = 1'b1;
        step();

        // 1: four filters, no back-pressure
        kick(4, 16, 100);
        wait_done("t1_done", 60);
        check_batch("t1", 4, 16, 100);
        check_eq("t1_issue_span", last_rd - first_rd, 3);
        check_eq("t1_first_wv_lat", first_wv - first_rd, 4);
        check_eq("t1_done_after_wr", done_cyc - last_wr, 1);
        step();

        // 2: empty batch
        kick(0, 5, 5);
        wait_done("t2_done", 20);
        check_eq("t2_done_lat", done_cyc - start_cyc, 2);
        check_eq("t2_no_rd", rd_cnt, 0);
        check_eq("t2_no_wv", wv_cnt, 0);
        step();

        // 3: eight filters with the write port stalled for 20 cycles
        mif.wr_ready = 1'b0;
        kick(8, 40, 200);
        repeat (8) step();
        held_data = mif.wr_data;
        held_addr = mif.wr_addr;
        repeat (12) step();
        check_eq("t3_rd_stop", rd_cnt, 4);
        check_eq("t3_hold_valid", mif.wr_valid, 1);
        check_eq("t3_hold_addr", mif.wr_addr, held_addr);
        check_eq("t3_hold_addr_val", held_addr, 200);
        check_eq("t3_hold_data", mif.wr_data, held_data);
        check_eq("t3_hold_data_val", held_data, gold_xform(filt_of(40)));
        mif.wr_ready = 1'b1;
        wait_done("t3_done", 80);
        check_batch("t3", 8, 40, 200);
`ifdef FXF_STALL_CNT_EN
        check_eq("t6_stall_cnt", stall_cycles, 16'(stall_mon));
`endif
        step();

        // 4: address wrap
        kick(3, 1022, 1023);
`ifdef FXF_STALL_CNT_EN
        check_eq("t6_stall_clear", stall_cycles, 0);
`endif
        wait_done("t4_done", 40);
        check_batch("t4", 3, 1022, 1023);
        step();

        // 5: reset mid-batch, then a clean batch with an ignored start
        kick(8, 300, 500);
        repeat (3) step();
        d0 = done_cnt;
        rstn = 1'b0;
        #1;
        check_reset("t5_rst");
        step();
        step();
        rstn = 1'b1;
        repeat (10) step();
        check_eq("t5_no_done", done_cnt, d0);
        check_reset("t5_after");
        kick(2, 600, 700);
        repeat (3) step();
        check_eq("t5_busy_pre_ign", busy, 1);
        num_filters  = 11'd5;
        base_rd_addr = 10'd10;
        base_wr_addr = 10'd20;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t5_done", 40);
        repeat (10) step();
        check_batch("t5", 2, 600, 700);
        check_eq("t5_one_done", done_cnt, 1);
        check_eq("t5_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
